bit_count_engine: RTL and testbench
===================================

# bit_count_engine

Parametrised population-count engine and the successor to the lab 4 8-bit bit counter. It captures a WIDTH-bit operand on a start handshake and counts set bits (or clear bits, selectable per operation), examining STEP bits per cycle. It terminates early once no set bits remain and holds the result until the next operation. It sits between the switch/register input stage and the HEX display drivers, and is reusable wherever a multi-cycle popcount is needed.

## Interface
- WIDTH, 16, operand width; ≥ 2.
- STEP, 2, bits examined per RUN cycle; ≥ 1; WIDTH % STEP == 0 (elaboration error otherwise).
- CW (localparam), $clog2(WIDTH+1), count width.
- IW (localparam), $clog2(WIDTH), index width.
- Reset is `reset`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  level request; sampled only in IDLE and DONE.
- data  in  WIDTH  operand; sampled only at the accept edge.
- count_zeros  in  1  0 = count ones, 1 = count zeros; sampled only at the accept edge.
- count  out  CW  result; valid while done = 1; held in IDLE.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- first_idx  out  IW  lowest set-bit index of effective operand (macro only).
- first_valid  out  1  effective operand nonzero (macro only).

## Operation
- States: IDLE, RUN, DONE. All state and datapath registers are updated on posedge clk.
- IDLE:
  - If start = 1, this edge is the accept edge E.
  - At E: A <= count_zeros ? ~data : data; count <= 0; pos <= 0; go to RUN.
  - If start = 0, remain in IDLE. count keeps its last result; it is not cleared.
- RUN:
  - If A == 0: go to DONE; count unchanged.
  - Else: count <= count + popcount(A[STEP-1:0]); A <= A >> STEP; pos <= pos + STEP; stay in RUN.
- DONE:
  - Stay while start = 1. Go to IDLE on the first edge where start = 0.
  - A new operation therefore requires start to drop and rise again. There is no auto-restart.
- start, data and count_zeros are ignored in RUN. Toggling start mid-RUN has no effect.
- count cannot overflow: the maximum is WIDTH, which fits in CW bits.
- Reset, in any state including mid-RUN:
  - Next state is IDLE.
  - count = 0, busy = 0, done = 0, A = 0, pos = 0, first_idx = 0, first_valid = 0.

## Timing
- Let h = index of the highest set bit of the effective operand.
- N = ceil((h+1)/STEP), with N = 0 for a zero operand.
- busy is high from edge E+1 through edge E+N+1, i.e. N+1 cycles.
- done rises after edge E+N+1, with count final at the same edge.
- Worst case is done at E + WIDTH/STEP + 1. For WIDTH=16, STEP=2 that is E+9.
- done falls one edge after start is sampled low in DONE. The engine is in IDLE that cycle and can accept at the next edge.
- Minimum turnaround between accepts is N+3 cycles.
- Outputs are registered state decodes, with no combinational path from inputs to outputs.

## Configuration
- BIT_COUNT_FIRST_IDX_EN defined:
  - first_idx and first_valid ports exist.
  - In RUN, on the first cycle where A[STEP-1:0] != 0 and first_valid = 0, latch first_idx <= pos + (lowest set index within the chunk), and set first_valid <= 1.
  - Both outputs are cleared at the accept edge and held through DONE and IDLE like count.
  - The extra latency is zero.
- Macro undefined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, STEP=2, data=16'hFFFF, count_zeros=0, start held high:
  - count=16 and done rises at E+9.
  - done stays high while start is high, then falls one cycle after start drops.
  - first_idx=0.
- data=16'h0000, count_zeros=0 → count=0, done at E+1, first_valid=0. Then count_zeros=1 on the same data → count=16, done at E+9.
- data=16'h0040 → count=1, done at E+5 (N=4), first_idx=6, first_valid=1. count is still 1 in IDLE after start drops.
- Start accepted with data=16'h8001:
  - Toggle start and change data during RUN; these have no effect, giving count=2 and done at E+9.
  - Repeat and assert reset at E+3 → at E+4 busy=0, done=0, count=0, and state is IDLE.
- WIDTH=8, STEP=1, data=8'hA5 → count=4, done at E+9, first_idx=0. This is the legacy 8-bit equivalent.
- WIDTH=12, STEP=3, data=12'h800 → count=1, done at E+5, first_idx=11.

Source files
------------

// File: rtl/bit_count_engine.sv
// -----------------------------------------------------------------------------
// bit_count_engine
//
// Multi-cycle population-count engine. A WIDTH-bit operand is captured on the
// start handshake. The engine then counts its set bits, or its clear bits when
// count_zeros is high at capture. It examines STEP bits per RUN cycle. It stops
// early once no set bits remain in the shifted operand, and it holds the result
// until the next operation is accepted.
//
// Optional feature macro: BIT_COUNT_FIRST_IDX_EN
//   When defined, the first_idx / first_valid ports report the lowest set-bit
//   index of the effective operand. This adds no latency.
//
// Parameters:
//   WIDTH        operand width (>= 2)
//   STEP         bits examined per RUN cycle (>= 1, divides WIDTH)
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   start        level request, sampled only in IDLE and DONE
//   data         operand, sampled at the accept edge
//   count_zeros  0 = count ones, 1 = count zeros, sampled at the accept edge
//   count        result, valid while done = 1, held in IDLE
//   busy         high while running
//   done         high while the result is presented
//   first_idx    lowest set-bit index of effective operand (macro only)
//   first_valid  effective operand nonzero (macro only)
// -----------------------------------------------------------------------------
module bit_count_engine #(
  parameter int  WIDTH = 16,
  parameter int  STEP  = 2,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             count_zeros,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
`ifdef BIT_COUNT_FIRST_IDX_EN
  ,
  output logic [IW-1:0]    first_idx,
  output logic             first_valid
`endif
);

  // Reject parameter sets for which the operand cannot be split evenly into chunks.
  generate
    if ((WIDTH < 2) || (STEP < 1) || ((WIDTH % STEP) != 0)) begin : g_bad_params
      $error("bit_count_engine: need WIDTH >= 2, STEP >= 1 and WIDTH %% STEP == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] opnd, opnd_n;   // effective operand, shifted down as it is consumed
  logic [CW-1:0]    count_n;
  logic             busy_n, done_n;
  logic [STEP-1:0]  chunk;

  assign chunk = opnd[STEP-1:0];

  // Number of ones in one STEP-bit chunk.
  function automatic logic [CW-1:0] chunk_popcount(input logic [STEP-1:0] c);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < STEP; i++) begin
      n = n + {{(CW-1){1'b0}}, c[i]};
    end
    return n;
  endfunction

`ifdef BIT_COUNT_FIRST_IDX_EN
  logic [CW-1:0] pos, pos_n;        // bit index of chunk[0] within the original operand
  logic [IW-1:0] first_idx_n;
  logic          first_valid_n;

  // Lowest set index inside one chunk. The scan runs downwards so that the last hit wins.
  function automatic logic [IW-1:0] chunk_lowest(input logic [STEP-1:0] c);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = STEP - 1; i >= 0; i--) begin
      if (c[i]) begin
        idx = IW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction
`else
  // Without the feature there is no position tracking; only the popcount path exists.
`endif

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_n       = state;
    opnd_n        = opnd;
    count_n       = count;
`ifdef BIT_COUNT_FIRST_IDX_EN
    pos_n         = pos;
    first_idx_n   = first_idx;
    first_valid_n = first_valid;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          opnd_n        = count_zeros ? ~data : data;
          count_n       = {CW{1'b0}};
`ifdef BIT_COUNT_FIRST_IDX_EN
          pos_n         = {CW{1'b0}};
          first_idx_n   = {IW{1'b0}};
          first_valid_n = 1'b0;
`endif
          state_n       = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        // Early exit: once no set bits remain, the remaining chunks cannot add anything.
        if (opnd == {WIDTH{1'b0}}) begin
          state_n = DONE;
        end else begin
          count_n = count + chunk_popcount(chunk);
          opnd_n  = opnd >> STEP;
`ifdef BIT_COUNT_FIRST_IDX_EN
          pos_n   = pos + CW'(STEP);
          if ((chunk != {STEP{1'b0}}) && !first_valid) begin
            first_idx_n   = IW'(pos + CW'(chunk_lowest(chunk)));
            first_valid_n = 1'b1;
          end else begin
            first_idx_n   = first_idx;
            first_valid_n = first_valid;
          end
`endif
          state_n = RUN;
        end
      end
      DONE: begin
        // Leaving DONE requires start to drop, so a held request never restarts.
        if (start) begin
          state_n = DONE;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      opnd        <= {WIDTH{1'b0}};
      count       <= {CW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef BIT_COUNT_FIRST_IDX_EN
      pos         <= {CW{1'b0}};
      first_idx   <= {IW{1'b0}};
      first_valid <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      opnd        <= opnd_n;
      count       <= count_n;
      busy        <= busy_n;
      done        <= done_n;
`ifdef BIT_COUNT_FIRST_IDX_EN
      pos         <= pos_n;
      first_idx   <= first_idx_n;
      first_valid <= first_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_count_engine.sv
// -----------------------------------------------------------------------------
// tb_bit_count_engine
//
// Self-checking bench for bit_count_engine. It uses three instances:
// 16/2, 8/1 and 12/3. For each operation, the bench computes the expected count,
// completion latency and lowest set index from its own model. It pushes those
// values to a scoreboard when it drives the operation, and pops them when done
// rises.
// -----------------------------------------------------------------------------
module tb_bit_count_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [15:0] data;
  logic        cz;

  logic [4:0] count0;
  logic [3:0] count1, count2;
  logic       busy0, busy1, busy2, done0, done1, done2;
`ifdef BIT_COUNT_FIRST_IDX_EN
  logic [3:0] fidx0;
  logic [2:0] fidx1;
  logic [3:0] fidx2;
  logic       fv0, fv1, fv2;
`endif

  always #5 clk = ~clk;

  bit_count_engine #(.WIDTH(16), .STEP(2)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .data(data), .count_zeros(cz),
    .count(count0), .busy(busy0), .done(done0)
`ifdef BIT_COUNT_FIRST_IDX_EN
    , .first_idx(fidx0), .first_valid(fv0)
`endif
  );

  bit_count_engine #(.WIDTH(8), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .data(data[7:0]), .count_zeros(cz),
    .count(count1), .busy(busy1), .done(done1)
`ifdef BIT_COUNT_FIRST_IDX_EN
    , .first_idx(fidx1), .first_valid(fv1)
`endif
  );

  bit_count_engine #(.WIDTH(12), .STEP(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .data(data[11:0]), .count_zeros(cz),
    .count(count2), .busy(busy2), .done(done2)
`ifdef BIT_COUNT_FIRST_IDX_EN
    , .first_idx(fidx2), .first_valid(fv2)
`endif
  );

  int          sel;
  logic [31:0] m_count, m_fidx;
  logic        m_busy, m_done, m_fv;

  // Select the outputs of the instance under test.
  always_comb begin
    m_fidx = 32'd0;
    m_fv   = 1'b0;
    case (sel)
      1: begin
        m_count = 32'(count1); m_busy = busy1; m_done = done1;
`ifdef BIT_COUNT_FIRST_IDX_EN
        m_fidx = 32'(fidx1); m_fv = fv1;
`endif
      end
      2: begin
        m_count = 32'(count2); m_busy = busy2; m_done = done2;
`ifdef BIT_COUNT_FIRST_IDX_EN
        m_fidx = 32'(fidx2); m_fv = fv2;
`endif
      end
      default: begin
        m_count = 32'(count0); m_busy = busy0; m_done = done0;
`ifdef BIT_COUNT_FIRST_IDX_EN
        m_fidx = 32'(fidx0); m_fv = fv0;
`endif
      end
    endcase
  end

  typedef struct {
    int cnt;
    int lat;
    int fidx;
    int fv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: popcount, latency N+1 and lowest set index of the effective operand.
  task automatic model_push(input int w, input int step, input logic [15:0] d, input logic cz_i);
    logic [15:0] eff;
    exp_t        e;
    int          h;
    eff = cz_i ? ~d : d;
    e.cnt = 0; e.fidx = 0; e.fv = 0; h = -1;
    for (int i = 0; i < w; i++) begin
      if (eff[i]) begin
        e.cnt++;
        h = i;
        if (e.fv == 0) begin
          e.fidx = i;
          e.fv   = 1;
        end
      end
    end
    e.lat = (h < 0) ? 1 : ((h + step) / step) + 1;
    sb.push_back(e);
  endtask

  task automatic run_op(input int sel_i, input logic [15:0] d, input logic cz_i,
                        input int hold, input bit disturb);
    int   w, step, lat;
    bit   got;
    exp_t e;
    case (sel_i)
      1:       begin w = 8;  step = 1; end
      2:       begin w = 12; step = 3; end
      default: begin w = 16; step = 2; end
    endcase
    sel = sel_i;
    @(negedge clk);
    data = d; cz = cz_i;
    start_v = 3'b000;
    start_v[sel_i] = 1'b1;
    model_push(w, step, d, cz_i);
    @(posedge clk); #1;                        // accept edge E
    check_val("busy_after_accept", 32'(m_busy), 32'd1);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (m_done) begin
        got = 1'b1; lat = k;
        break;
      end
      if (disturb) begin
        start_v[sel_i] = ~start_v[sel_i];
        data = 16'($urandom);
        cz = ~cz;
      end
    end
    if (got) begin
      check_val("latency", 32'(lat), 32'(sb[0].lat));
    end else begin
      check_val("done_timeout", 32'd0, 32'd1);
    end
    e = sb.pop_front();
    check_val("count", m_count, 32'(e.cnt));
    check_val("busy_in_done", 32'(m_busy), 32'd0);
`ifdef BIT_COUNT_FIRST_IDX_EN
    check_val("first_valid", 32'(m_fv), 32'(e.fv));
    if (e.fv != 0) begin
      check_val("first_idx", m_fidx, 32'(e.fidx));
    end else begin
      check_val("first_idx_zero", m_fidx, 32'd0);
    end
`endif
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_val("done_held", 32'(m_done), 32'd1);
    end
    start_v = 3'b000;
    @(posedge clk); #1;
    check_val("done_fall", 32'(m_done), 32'd0);
    check_val("busy_idle", 32'(m_busy), 32'd0);
    check_val("count_held_idle", m_count, 32'(e.cnt));
    @(posedge clk);
  endtask

  // Stop a runaway simulation with a reported failure.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start_v = 3'b000; data = 16'h0000; cz = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_count", 32'(count0), 32'd0);
    check_val("reset_busy", 32'(busy0), 32'd0);
    check_val("reset_done", 32'(done0), 32'd0);
    check_val("reset_done1", 32'(done1), 32'd0);
    check_val("reset_done2", 32'(done2), 32'd0);
`ifdef BIT_COUNT_FIRST_IDX_EN
    check_val("reset_fv", 32'(fv0), 32'd0);
`endif
    reset = 1'b0;

    run_op(0, 16'hFFFF, 1'b0, 3, 1'b0);   // count 16, E+9, start held
    run_op(0, 16'h0000, 1'b0, 0, 1'b0);   // count 0, E+1
    run_op(0, 16'h0000, 1'b1, 0, 1'b0);   // count zeros: 16, E+9
    run_op(0, 16'h0040, 1'b0, 0, 1'b0);   // count 1, E+5, idx 6
    run_op(0, 16'h8001, 1'b0, 0, 1'b1);   // inputs disturbed mid-run

    // Reset asserted at E+3 aborts the operation.
    sel = 0;
    @(negedge clk);
    data = 16'h8001; cz = 1'b0; start_v = 3'b001;
    @(posedge clk);                       // E
    @(negedge clk);
    start_v = 3'b000;
    repeat (3) @(posedge clk);            // E+3
    #1;
    check_val("busy_before_reset", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;                   // E+4
    check_val("abort_busy", 32'(busy0), 32'd0);
    check_val("abort_done", 32'(done0), 32'd0);
    check_val("abort_count", 32'(count0), 32'd0);
`ifdef BIT_COUNT_FIRST_IDX_EN
    check_val("abort_fv", 32'(fv0), 32'd0);
`endif
    reset = 1'b0;

    run_op(0, 16'h8001, 1'b0, 0, 1'b0);   // engine usable again from IDLE
    run_op(1, 16'h00A5, 1'b0, 1, 1'b0);   // 8/1: count 4, E+9
    run_op(2, 16'h0800, 1'b0, 0, 1'b0);   // 12/3: count 1, E+5, idx 11
    run_op(2, 16'h0000, 1'b1, 0, 1'b0);   // 12/3: count 12

    for (int r = 0; r < 8; r++) begin
      run_op(r % 3, 16'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
